// File: rtl/potential_update_scheduler.sv
// potential_update_scheduler: walks every neuron once per timestep through the shared LIF adder
// (read operands, load adder, wait for result, write back potential and spike flag).
module potential_update_scheduler #(
    parameter int          NUM_NEURONS  = 30,
    parameter int          ADDER_LAT    = 2,
    parameter logic [31:0] THRESH_RESET = 32'h42200000
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   start,
    input  logic                   cfg_we,
    input  logic [31:0]            cfg_threshold,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             mem_addr,
    output logic                   mem_rd,
    input  logic [31:0]            pot_rdata,
    input  logic [31:0]            wgt_rdata,
    output logic                   adder_clear,
    output logic                   adder_set,
    output logic [31:0]            adder_weight,
    output logic [31:0]            adder_potential,
    output logic [31:0]            adder_threshold,
    input  logic [31:0]            adder_result,
    input  logic                   adder_spike,
    output logic                   pot_we,
    output logic [31:0]            pot_wdata,
    output logic [NUM_NEURONS-1:0] spike_vector
);
    localparam int WW = ADDER_LAT > 1 ? $clog2(ADDER_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, READ, LOAD, WAIT, WB, DONE} state_t;

    state_t        state, state_nx;
    logic [4:0]    n;
    logic [WW-1:0] wcnt;
    logic [31:0]   res;
    logic          spk;
    logic          last_wait, last_n;

    assign last_wait   = wcnt == WW'(ADDER_LAT - 1);
    assign last_n      = n == 5'(NUM_NEURONS - 1);
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign mem_rd      = state == READ;
    assign adder_set   = state == READ;
    assign adder_clear = state == CLEAR;
    assign pot_we      = state == WB;
    assign mem_addr    = n;
    assign pot_wdata   = res;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = READ;
            READ:    state_nx = LOAD;
            LOAD:    state_nx = WAIT;
            WAIT:    state_nx = last_wait ? WB : WAIT;
            WB:      state_nx = last_n ? DONE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;

    // adder operands stay registered so the adder sees stable inputs for the whole WAIT window
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            n               <= '0;
            wcnt            <= '0;
            res             <= '0;
            spk             <= 1'b0;
            adder_weight    <= '0;
            adder_potential <= '0;
            adder_threshold <= THRESH_RESET;
            spike_vector    <= '0;
        end else begin
            if (state == IDLE && cfg_we) adder_threshold <= cfg_threshold;
            if (state == CLEAR) begin
                n            <= '0;
                spike_vector <= '0;
            end
            if (state == LOAD) begin
                adder_weight    <= wgt_rdata;
                adder_potential <= pot_rdata;
            end
            wcnt <= (state == WAIT && !last_wait) ? wcnt + 1'b1 : '0;
            if (state == WAIT && last_wait) begin
                res <= adder_result;
                spk <= adder_spike;
            end
            if (state == WB) begin
                spike_vector[n] <= spk;
                n               <= last_n ? 5'd0 : n + 5'd1;
            end
            if (state == DONE) n <= '0;
        end
    end
endmodule
